dcache1_inv_issue: RTL and testbench

- Producer side of the dcache1 invalidate ("puke") port. Receives set-invalidate requests from the L2/coherence side and buffers them in a FIFO.
- Drives the 6-lane puke_en/puke_addr bus that clears valid bits in every dcache1 way.
- Also runs a full-cache flush sweep over all 128 sets (64 even-bank, 64 odd-bank).

---
 rtl/dcache1_inv_issue_pkg.sv | 21 ++
 rtl/dcache1_inv_fifo.sv | 86 ++++++++
 rtl/dcache1_inv_issue.sv | 125 ++++++++++++
 tb/tb_dcache1_inv_issue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache1_inv_issue_pkg.sv
// rtl/dcache1_inv_issue_pkg.sv - shared constants, lane slice macro and FSM encoding for the dcache1 invalidate issuer
`ifndef DCACHE1_INV_ISSUE_PKG_SV
`define DCACHE1_INV_ISSUE_PKG_SV

// Lane i of puke_addr occupies bits [7i+6:7i].
`define DC1_PUKE_SLICE(i) (i)*DC1_SET_BITS +: DC1_SET_BITS

package dcache1_inv_issue_pkg;
  localparam int DC1_PUKE_LANES = 6;
  localparam int DC1_SET_BITS   = 7;
  localparam int DC1_SETS       = 128;
  localparam int DC1_SWEEP_LAST = (DC1_SETS + DC1_PUKE_LANES - 1) / DC1_PUKE_LANES - 1;

  typedef enum logic [1:0] {
    INV_IDLE  = 2'd0,
    INV_DRAIN = 2'd1,
    INV_FLUSH = 2'd2
  } inv_state_e;
endpackage

`endif

// File: rtl/dcache1_inv_fifo.sv
// rtl/dcache1_inv_fifo.sv - circular buffer of set indexes with coalesce match, single push and 0..LANES multi-pop
module dcache1_inv_fifo
  import dcache1_inv_issue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LANES = DC1_PUKE_LANES,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int PW    = $clog2(LANES + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            push,
  input  logic [DC1_SET_BITS-1:0]         push_idx,
  input  logic [PW-1:0]                   pop_n,
  output logic [CW-1:0]                   count,
  output logic                            hit,
  output logic [DC1_SET_BITS*LANES-1:0]   peek
);
  localparam int AW = $clog2(DEPTH);

  logic [DC1_SET_BITS-1:0] mem_q [DEPTH];
  logic [DC1_SET_BITS-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [AW-1:0]           rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    push_w;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (mem_q[i] == push_idx)) hit = 1'b1;
    end
  end

  // A coalesced request is handshaken upstream but never written.
  assign push_w = push && !hit && !clear;
  assign count  = cnt_q;

  always_comb begin
    peek = '0;
    for (int k = 0; k < LANES; k++) begin
      peek[`DC1_PUKE_SLICE(k)] = mem_q[rd_q + AW'(k)];
    end
  end

  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      vld_d = '0;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (PW'(k) < pop_n) vld_d[rd_q + AW'(k)] = 1'b0;
      end
      rd_d = rd_q + AW'(pop_n);
      if (push_w) begin
        mem_d[wr_q] = push_idx;
        vld_d[wr_q] = 1'b1;
        wr_d        = wr_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(push_w) - CW'(pop_n);
    end
  end

  always_ff @(negedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      vld_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/dcache1_inv_issue.sv
// rtl/dcache1_inv_issue.sv - dcache1 puke port producer: queued set invalidates plus full-cache flush sweep
module dcache1_inv_issue
  import dcache1_inv_issue_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int LANES       = DC1_PUKE_LANES,
  parameter int PADDR_WIDTH = 44
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            inv_req_valid,
  input  logic [PADDR_WIDTH-8:0]          inv_req_line,
  output logic                            inv_req_ready,
  input  logic                            inv_all,
  input  logic                            puke_hold,
  output logic [LANES-1:0]                puke_en,
  output logic [DC1_SET_BITS*LANES-1:0]   puke_addr,
  output logic                            inv_flush_done,
  output logic                            inv_idle
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(LANES + 1);
  localparam int SW = $clog2(DC1_SWEEP_LAST + 1);

  inv_state_e                      state_q, state_d;
  logic [SW-1:0]                   sweep_q, sweep_d;
  logic [LANES-1:0]                en_q, en_d;
  logic [DC1_SET_BITS*LANES-1:0]   addr_q, addr_d;
  logic                            done_q, done_d;
  logic [CW-1:0]                   fifo_cnt;
  logic                            fifo_hit;
  logic [DC1_SET_BITS*LANES-1:0]   fifo_peek;
  logic [PW-1:0]                   pop_n;
  logic                            push, flush_start, unused_line;
  logic [7:0]                      set_idx;

  assign unused_line   = ^inv_req_line[PADDR_WIDTH-8:DC1_SET_BITS];
  assign inv_req_ready = rst && (state_q != INV_FLUSH) && (fifo_cnt < CW'(DEPTH));
  assign push          = inv_req_valid && inv_req_ready;
  assign flush_start   = inv_all && (state_q != INV_FLUSH);

  // Popping is allowed from IDLE too so a fresh entry issues on the very next edge.
  always_comb begin
    pop_n = '0;
    if ((state_q != INV_FLUSH) && !inv_all && !puke_hold) begin
      pop_n = (fifo_cnt > CW'(LANES)) ? PW'(LANES) : PW'(fifo_cnt);
    end
  end

  dcache1_inv_fifo #(.DEPTH(DEPTH), .LANES(LANES)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush_start),
    .push     (push),
    .push_idx (inv_req_line[DC1_SET_BITS-1:0]),
    .pop_n    (pop_n),
    .count    (fifo_cnt),
    .hit      (fifo_hit),
    .peek     (fifo_peek)
  );

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    en_d    = '0;
    addr_d  = '0;
    done_d  = 1'b0;
    set_idx = '0;
    case (state_q)
      INV_FLUSH: begin
        if (!puke_hold) begin
          for (int k = 0; k < LANES; k++) begin
            set_idx = 8'(sweep_q) * 8'(LANES) + 8'(k);
            if (set_idx < 8'(DC1_SETS)) begin
              en_d[k]                    = 1'b1;
              addr_d[`DC1_PUKE_SLICE(k)] = set_idx[DC1_SET_BITS-1:0];
            end
          end
          if (sweep_q == SW'(DC1_SWEEP_LAST)) begin
            done_d  = 1'b1;
            state_d = INV_IDLE;
            sweep_d = '0;
          end else begin
            sweep_d = sweep_q + 1'b1;
          end
        end
      end
      default: begin
        if (inv_all) begin
          state_d = INV_FLUSH;
          sweep_d = '0;
        end else begin
          for (int k = 0; k < LANES; k++) begin
            if (PW'(k) < pop_n) begin
              en_d[k]                    = 1'b1;
              addr_d[`DC1_PUKE_SLICE(k)] = fifo_peek[`DC1_PUKE_SLICE(k)];
            end
          end
          state_d = ((push && !fifo_hit) || (fifo_cnt != CW'(pop_n))) ? INV_DRAIN : INV_IDLE;
        end
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q <= INV_IDLE;
      sweep_q <= '0;
      en_q    <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign puke_en        = en_q;
  assign puke_addr      = addr_q;
  assign inv_flush_done = done_q;
  assign inv_idle       = (state_q == INV_IDLE) && (fifo_cnt == '0) && (en_q == '0);
endmodule

// File: tb/tb_dcache1_inv_issue.sv
// tb/tb_dcache1_inv_issue.sv - directed self-checking bench for dcache1_inv_issue
module tb_dcache1_inv_issue;
  logic        clk = 1'b1;
  logic        rst = 1'b0;
  logic        inv_req_valid = 1'b0;
  logic [36:0] inv_req_line = '0;
  logic        inv_req_ready;
  logic        inv_all = 1'b0;
  logic        puke_hold = 1'b0;
  logic [5:0]  puke_en;
  logic [41:0] puke_addr;
  logic        inv_flush_done;
  logic        inv_idle;

  int n_cmp = 0;
  int n_err = 0;

  dcache1_inv_issue dut (
    .clk            (clk),
    .rst            (rst),
    .inv_req_valid  (inv_req_valid),
    .inv_req_line   (inv_req_line),
    .inv_req_ready  (inv_req_ready),
    .inv_all        (inv_all),
    .puke_hold      (puke_hold),
    .puke_en        (puke_en),
    .puke_addr      (puke_addr),
    .inv_flush_done (inv_flush_done),
    .inv_idle       (inv_idle)
  );

  // DUT state changes on the falling edge; the bench samples and drives at the rising edge.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
  endtask

  function automatic logic [41:0] lanes_seq(input int first, input int n);
    logic [41:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[7*k +: 7] = 7'(first + k);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] seen;
    logic [5:0]   last_en, held_en;
    logic [41:0]  last_addr;
    logic [6:0]   sa;
    logic         got_done;
    int           nvec, dups, ndone, nen;

    // reset
    repeat (3) tick();
    chk("ready_in_reset", inv_req_ready, 0);
    rst = 1'b1;
    tick();
    chk("rst_ready", inv_req_ready, 1);
    chk("rst_idle", inv_idle, 1);
    chk("rst_en", puke_en, 0);
    chk("rst_addr", puke_addr, 0);
    chk("rst_done", inv_flush_done, 0);

    // single request, two-edge latency
    inv_req_valid = 1'b1;
    inv_req_line  = {30'h2ABCDEF, 7'h05};
    tick();
    inv_req_valid = 1'b0;
    chk("single_not_yet", puke_en, 0);
    tick();
    chk("single_en", puke_en, 6'b000001);
    chk("single_addr", puke_addr, 42'h05);
    tick();
    chk("single_idle_after", inv_idle, 1);
    chk("single_en_clear", puke_en, 0);

    // 8 entries under hold, then drain in two vectors
    puke_hold = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      inv_req_valid = 1'b1;
      inv_req_line  = 37'(i);
      tick();
    end
    inv_req_valid = 1'b0;
    chk("hold_en", puke_en, 0);
    puke_hold = 1'b0;
    tick();
    chk("burst1_en", puke_en, 6'b111111);
    chk("burst1_addr", puke_addr, lanes_seq(1, 6));
    tick();
    chk("burst2_en", puke_en, 6'b000011);
    chk("burst2_addr", puke_addr, lanes_seq(7, 2));
    tick();
    chk("burst_drained", inv_idle, 1);

    // coalescing of a duplicate index
    puke_hold     = 1'b1;
    inv_req_valid = 1'b1;
    inv_req_line  = {30'h1, 7'h41};
    tick();
    chk("dup_ready", inv_req_ready, 1);
    tick();
    inv_req_valid = 1'b0;
    puke_hold     = 1'b0;
    tick();
    chk("dup_en", puke_en, 6'b000001);
    chk("dup_addr", puke_addr, 42'h41);
    tick();
    chk("dup_once", puke_en, 0);
    chk("dup_idle", inv_idle, 1);

    // fill to DEPTH, ready drops, reopens after first pop
    puke_hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      inv_req_valid = 1'b1;
      inv_req_line  = 37'(8'h10 + i);
      tick();
    end
    inv_req_valid = 1'b0;
    chk("full_ready", inv_req_ready, 0);
    puke_hold = 1'b0;
    tick();
    chk("full_reopen_ready", inv_req_ready, 1);
    chk("full_pop1_en", puke_en, 6'b111111);
    chk("full_pop1_addr", puke_addr, lanes_seq(8'h10, 6));
    tick();
    tick();
    chk("full_pop3_en", puke_en, 6'b001111);
    chk("full_pop3_addr", puke_addr, lanes_seq(8'h1C, 4));
    tick();
    chk("full_drained", inv_idle, 1);

    // flush with 4 queued entries, a redundant inv_all and a one-cycle hold
    puke_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inv_req_valid = 1'b1;
      inv_req_line  = 37'(8'h30 + i);
      tick();
    end
    inv_req_valid = 1'b0;
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    chk("flush_entry_en", puke_en, 0);
    chk("flush_ready", inv_req_ready, 0);
    seen = '0; nvec = 0; dups = 0; got_done = 1'b0;
    held_en = '1; last_en = '0; last_addr = '0;
    for (int it = 0; it < 40 && !got_done; it++) begin
      inv_all   = (it == 5);
      puke_hold = (it == 8);
      tick();
      if (it == 8) held_en = puke_en;
      for (int k = 0; k < 6; k++) begin
        if (puke_en[k]) begin
          sa = puke_addr[7*k +: 7];
          if (seen[sa]) dups++;
          seen[sa] = 1'b1;
        end
      end
      if (puke_en != 0) nvec++;
      if (inv_flush_done) begin
        got_done  = 1'b1;
        last_en   = puke_en;
        last_addr = puke_addr;
      end
    end
    inv_all   = 1'b0;
    puke_hold = 1'b0;
    chk("flush_done_seen", got_done, 1);
    chk("flush_vectors", nvec, 22);
    chk("flush_dups", dups, 0);
    chk("flush_cov_lo", seen[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("flush_cov_hi", seen[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("flush_hold_en", held_en, 0);
    chk("flush_last_en", last_en, 6'b000011);
    chk("flush_last_addr", last_addr, lanes_seq(126, 2));
    tick();
    chk("flush_after_en", puke_en, 0);
    chk("flush_after_idle", inv_idle, 1);

    // reset in the middle of a flush
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    repeat (10) tick();
    chk("midflush_active", puke_en, 6'b111111);
    rst = 1'b0;
    tick();
    chk("abort_en", puke_en, 0);
    chk("abort_addr", puke_addr, 0);
    chk("abort_done", inv_flush_done, 0);
    chk("abort_ready", inv_req_ready, 0);
    rst = 1'b1;
    tick();
    chk("abort_idle", inv_idle, 1);
    chk("abort_ready_after", inv_req_ready, 1);
    ndone = 0; nen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (inv_flush_done) ndone++;
      if (puke_en != 0) nen++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_no_issue", nen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
